// File: rtl/m_shiftsequencer_pkg.sv
// m_shiftsequencer_pkg: op, counter-select and FSM state encodings shared by the shift sequencer
package m_shiftsequencer_pkg;
  typedef logic [1:0] sh_op_t;
  typedef logic [1:0] shsel_t;
  localparam sh_op_t SH_SLL    = 2'b00;
  localparam sh_op_t SH_SRL    = 2'b01;
  localparam sh_op_t SH_SRA    = 2'b11;
  localparam sh_op_t SH_BALIGN = 2'b10;
  localparam shsel_t SHSEL_LOADB    = 2'b00;
  localparam shsel_t SHSEL_LOADBYTE = 2'b01;
  localparam shsel_t SHSEL_COUNT    = 2'b10;
  localparam shsel_t SHSEL_HOLD     = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;
endpackage

// File: rtl/m_shiftsequencer_if.sv
// m_shiftsequencer_if: request/result bus between the core and the shift sequencer
interface m_shiftsequencer_if;
  import m_shiftsequencer_pkg::*;
  logic        start;
  sh_op_t      op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  modport master (output start, op, a, shamt, input busy, done, result);
  modport slave  (input start, op, a, shamt, output busy, done, result);
endinterface

// File: rtl/m_shiftsequencer_dp.sv
// m_shiftsequencer_dp: operand register with load and one-bit left/right/arithmetic shift
module m_shiftsequencer_dp #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic         left,
  input  logic         arith,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (load) q <= d;
    else if (shift) q <= left ? {q[W-2:0], 1'b0} : {arith & q[W-1], q[W-1:1]};
endmodule

// File: rtl/m_shiftsequencer.sv
// m_shiftsequencer: multi-cycle shift sequencer driving the shift counter; SHIFTSEQ_BYTEALIGN_EN enables op=10 byte-align
module m_shiftsequencer
  import m_shiftsequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  m_shiftsequencer_if.slave   bus,
  input  logic                lastshift,
  output logic [1:0]          s_shiftsel,
  output logic [4:0]          cnt_b
);
  logic [1:0]      state;
  sh_op_t          opq;
  logic            done_q;
  logic [XLEN-1:0] result_q, opreg;
  shsel_t          load_sel;
  logic            accept;
  assign accept = state == ST_IDLE && bus.start;
`ifdef SHIFTSEQ_BYTEALIGN_EN
  assign load_sel = opq == SH_BALIGN ? SHSEL_LOADBYTE : SHSEL_LOADB;
`else
  assign load_sel = SHSEL_LOADB;
`endif
  always_comb begin
    s_shiftsel = state == ST_LOAD ? load_sel : state == ST_SHIFT ? SHSEL_COUNT : SHSEL_HOLD;
    bus.busy   = state == ST_LOAD || state == ST_SHIFT;
  end
  assign bus.done   = done_q;
  assign bus.result = result_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= ST_IDLE;
      opq      <= SH_SLL;
      cnt_b    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state  <= state == ST_IDLE  ? (bus.start ? ST_LOAD : ST_IDLE) :
                state == ST_LOAD  ? ST_SHIFT :
                state == ST_SHIFT ? (lastshift ? ST_FIN : ST_SHIFT) : ST_IDLE;
      done_q <= state == ST_FIN;
      if (accept) begin
        opq   <= bus.op;
        cnt_b <= bus.shamt;
      end
      if (state == ST_FIN) result_q <= opreg;
    end
  // the SHIFT cycle that sees lastshift is the extra non-shifting cycle
  m_shiftsequencer_dp #(.W(XLEN)) u_dp (
    .clk  (clk),
    .load (accept),
    .shift(state == ST_SHIFT && !lastshift),
    .left (opq == SH_SLL),
    .arith(opq == SH_SRA),
    .d    (bus.a),
    .q    (opreg)
  );
endmodule

// File: tb/tb_m_shiftsequencer.sv
// tb_m_shiftsequencer: randomized and directed checks of the shift sequencer against a shift reference model
module tb_m_shiftsequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lastshift;
  logic [1:0]  s_shiftsel;
  logic [4:0]  cnt_b;
  logic [4:0]  cnt;
  int          vectors = 0;
  int          errs = 0;
  logic [31:0] last_result = '0;

  m_shiftsequencer_if bus ();

  m_shiftsequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .lastshift (lastshift),
    .s_shiftsel(s_shiftsel),
    .cnt_b     (cnt_b)
  );

  always #5 clk = ~clk;

  // partner shift counter: lastshift flags that the count was zero before this decrement
  always_ff @(posedge clk)
    case (s_shiftsel)
      2'b00:   cnt <= cnt_b;
      2'b01:   cnt <= {cnt_b[1:0], 3'b000};
      2'b10:   cnt <= cnt - 5'd1;
      default: cnt <= cnt;
    endcase
  assign lastshift = cnt == 5'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_balign(input logic [1:0] op);
`ifdef SHIFTSEQ_BYTEALIGN_EN
    return op == 2'b10;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_amount(input logic [1:0] op, input logic [4:0] shamt);
    return is_balign(op) ? 8 * int'(shamt[1:0]) : int'(shamt);
  endfunction

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input logic [4:0] shamt);
    logic signed [31:0] sa;
    int n;
    sa = a;
    n = ref_amount(op, shamt);
    return op == 2'b00 ? a << n : op == 2'b11 ? 32'(sa >>> n) : a >> n;
  endfunction

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [4:0] shamt, input bit repulse);
    int n, k;
    bit seen;
    logic [31:0] exp;
    n = ref_amount(op, shamt);
    exp = ref_shift(op, a, shamt);
    seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.shamt = shamt;
    @(posedge clk);
    for (k = 0; k < 120 && !seen; k++) begin
      @(negedge clk);
      bus.start = repulse && k <= n + 2 ? 1'b1 : 1'b0;
      bus.a = $urandom;
      bus.op = 2'($urandom);
      bus.shamt = 5'($urandom);
      if (k == 0) begin
        check("load_sel", 32'(s_shiftsel), is_balign(op) ? 32'd1 : 32'd0);
        check("busy_load", 32'(bus.busy), 32'd1);
      end
      if (k == 1) check("result_held", bus.result, last_result);
      if (bus.done) begin
        seen = 1;
        check("latency", 32'(k), 32'(n + 3));
        check("result", bus.result, exp);
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("result_hold", bus.result, exp);
    last_result = exp;
  endtask

  task automatic reset_mid_op;
    bit extra_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'hCAFE_F00D;
    bus.shamt = 5'd10;
    @(posedge clk);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_sel", 32'(s_shiftsel), 32'd3);
    rst_n = 1'b1;
    extra_done = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      extra_done |= bus.done;
    end
    check("rst_no_done", 32'(extra_done), 32'd0);
    last_result = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_sel", 32'(s_shiftsel), 32'd3);
    check("reset_cnt_b", 32'(cnt_b), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    check("start_in_reset", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    run(2'b00, 32'h0000_0001, 5'd31, 0);
    run(2'b11, 32'h8000_0000, 5'd4, 0);
    run(2'b01, 32'h8000_0000, 5'd4, 0);
    for (int o = 0; o < 4; o++) run(2'(o), 32'hDEAD_BEEF, 5'd0, 0);
    run(2'b10, 32'h1122_3344, 5'b00011, 0);
    run(2'b01, 32'h1234_5678, 5'd10, 1);
    run(2'b00, 32'h0F0F_0F0F, 5'd1, 0);
    reset_mid_op();
    run(2'b11, 32'h9000_0001, 5'd31, 0);
    for (int i = 0; i < 40; i++) run(2'($urandom), $urandom, 5'($urandom), bit'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
